// File: rtl/rsp_burst_mover_if.sv
// rtl/rsp_burst_mover_if.sv - AXI read/write channel bundle used by rsp_burst_mover
//
// Carries the five AXI channels used by the mover: AR, R, AW, W and B.
// Signal names keep the mover's point of view: o_* is driven by the mover and
// i_* by the memory side.
//   master : the mover (drives AR/AW/W valids and addresses, R/B readies)
//   slave  : the memory model or interconnect
interface rsp_burst_mover_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32
);
  logic              o_arvalid;
  logic              i_arready;
  logic [ADDR_W-1:0] o_araddr;
  logic [7:0]        o_arlen;

  logic              i_rvalid;
  logic              o_rready;
  logic [DATA_W-1:0] i_rdata;
  logic [1:0]        i_rresp;
  logic              i_rlast;

  logic              o_awvalid;
  logic              i_awready;
  logic [ADDR_W-1:0] o_awaddr;
  logic [7:0]        o_awlen;

  logic              o_wvalid;
  logic              i_wready;
  logic [DATA_W-1:0] o_wdata;
  logic              o_wlast;

  logic              i_bvalid;
  logic              o_bready;
  logic [1:0]        i_bresp;

  modport master (
    output o_arvalid, o_araddr, o_arlen, input i_arready,
    input  i_rvalid, i_rdata, i_rresp, i_rlast, output o_rready,
    output o_awvalid, o_awaddr, o_awlen, input i_awready,
    output o_wvalid, o_wdata, o_wlast, input i_wready,
    input  i_bvalid, i_bresp, output o_bready
  );

  modport slave (
    input  o_arvalid, o_araddr, o_arlen, output i_arready,
    output i_rvalid, i_rdata, i_rresp, i_rlast, input o_rready,
    input  o_awvalid, o_awaddr, o_awlen, output i_awready,
    input  o_wvalid, o_wdata, o_wlast, output i_wready,
    output i_bvalid, i_bresp, input o_bready
  );
endinterface

// File: rtl/rsp_burst_mover.sv
// rtl/rsp_burst_mover.sv - burst copy engine: AXI read -> external datapath -> FIFO -> AXI write
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   i_start                  one-cycle launch pulse (ignored while o_busy)
//   i_src_base, i_dst_base   burst-aligned byte base addresses
//   i_num_bursts             number of BURST_LEN-beat bursts to move
//   o_busy, o_done, o_err    transfer active, completion pulse, sticky response error
//   axi                      AR/R/AW/W/B channels (master side)
//   o_x, o_x_valid, o_x_last read beats handed to the external datapath
//   i_y, i_y_valid           processed beats returning, one per o_x beat, in order
module rsp_burst_mover #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 32,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic [15:0]       i_num_bursts,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  rsp_burst_mover_if.master axi,
  output logic [DATA_W-1:0] o_x,
  output logic              o_x_valid,
  output logic              o_x_last,
  input  logic [DATA_W-1:0] i_y,
  input  logic              i_y_valid
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = CNT_W + 2;
  localparam int BEAT_W = $clog2(BURST_LEN);

  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [CNT_W-1:0]  BL_CNT      = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [SUM_W-1:0]  BL_SUM      = SUM_W'(BURST_LEN);
  localparam logic [SUM_W-1:0]  DEPTH_SUM   = SUM_W'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} w_state_t;
  w_state_t state_q, state_d;

  logic              busy_q;
  logic              zero_done_q;
  logic              err_q;
  logic [15:0]       ar_left_q;
  logic [15:0]       b_left_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic              arvalid_q;
  logic [CNT_W-1:0]  inflight_q;
  logic [CNT_W-1:0]  fifo_count_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [BEAT_W-1:0] beat_q;
  logic [DATA_W-1:0] x_q;
  logic              x_valid_q;
  logic              x_last_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic start_ok, ar_hs, r_hs, aw_hs, b_hs;
  logic fifo_empty, fifo_full, push_req, push, pop, overflow;
  logic credit_ok, issue_ar;

  assign start_ok   = i_start && !busy_q;
  assign ar_hs      = arvalid_q && axi.i_arready;
  assign r_hs       = axi.i_rvalid && axi.o_rready;
  assign aw_hs      = axi.o_awvalid && axi.i_awready;
  assign b_hs       = axi.i_bvalid && axi.o_bready;
  assign pop        = axi.o_wvalid && axi.i_wready;

  assign fifo_empty = (fifo_count_q == '0);
  assign fifo_full  = (fifo_count_q == DEPTH_CNT);
  assign push_req   = busy_q && i_y_valid;
  // A beat arriving at a full FIFO is only safe if a pop frees a slot this cycle.
  assign overflow   = push_req && fifo_full && !pop;
  assign push       = push_req && !overflow;

  // Beats already reserved (in flight through R and the datapath) plus those
  // buffered must leave room for a whole new burst before another AR goes out.
  assign credit_ok  = (SUM_W'(fifo_count_q) + SUM_W'(inflight_q) + BL_SUM) <= DEPTH_SUM;
  assign issue_ar   = busy_q && !arvalid_q && (ar_left_q != '0) && credit_ok;

  assign o_busy        = busy_q;
  assign o_err         = err_q;
  assign o_x           = x_q;
  assign o_x_valid     = x_valid_q;
  assign o_x_last      = x_last_q;
  assign axi.o_arvalid = arvalid_q;
  assign axi.o_araddr  = araddr_q;
  assign axi.o_arlen   = 8'(BURST_LEN - 1);
  assign axi.o_awaddr  = awaddr_q;
  assign axi.o_awlen   = 8'(BURST_LEN - 1);
  assign axi.o_rready  = busy_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= i_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= W_IDLE;
      busy_q       <= 1'b0;
      zero_done_q  <= 1'b0;
      err_q        <= 1'b0;
      ar_left_q    <= '0;
      b_left_q     <= '0;
      araddr_q     <= '0;
      awaddr_q     <= '0;
      arvalid_q    <= 1'b0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      beat_q       <= '0;
      x_q          <= '0;
      x_valid_q    <= 1'b0;
      x_last_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= start_ok && (i_num_bursts == '0);

      if (start_ok) begin
        err_q <= 1'b0;
        if (i_num_bursts != '0) begin
          busy_q    <= 1'b1;
          araddr_q  <= i_src_base;
          awaddr_q  <= i_dst_base;
          ar_left_q <= i_num_bursts;
          b_left_q  <= i_num_bursts;
        end
      end else begin
        if ((r_hs && axi.i_rresp != 2'b00) || (b_hs && axi.i_bresp != 2'b00) || overflow) begin
          err_q <= 1'b1;
        end
        // Busy drops as the final B is accepted so it is already low in the o_done cycle.
        if (b_hs && b_left_q == 16'd1) begin
          busy_q <= 1'b0;
        end
      end

      if (ar_hs) begin
        arvalid_q <= 1'b0;
        araddr_q  <= araddr_q + BURST_BYTES;
        ar_left_q <= ar_left_q - 16'd1;
      end else if (issue_ar) begin
        arvalid_q <= 1'b1;
      end

      inflight_q <= inflight_q + (ar_hs ? BL_CNT : '0) - CNT_W'(push);

      x_valid_q <= r_hs;
      x_last_q  <= r_hs && axi.i_rlast;
      if (r_hs) begin
        x_q <= axi.i_rdata;
      end

      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        beat_q   <= beat_q + 1'b1;
      end
      fifo_count_q <= fifo_count_q + CNT_W'(push) - CNT_W'(pop);

      if (aw_hs) begin
        awaddr_q <= awaddr_q + BURST_BYTES;
      end
      if (b_hs) begin
        b_left_q <= b_left_q - 16'd1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    axi.o_awvalid = 1'b0;
    axi.o_wvalid  = 1'b0;
    axi.o_wlast   = 1'b0;
    axi.o_wdata   = '0;
    axi.o_bready  = 1'b0;
    o_done        = zero_done_q;
    case (state_q)
      W_IDLE: begin
        if (busy_q && b_left_q != '0 && fifo_count_q >= BL_CNT) begin
          state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        axi.o_awvalid = 1'b1;
        if (axi.i_awready) begin
          state_d = W_DATA;
        end
      end
      W_DATA: begin
        // FWFT: the head entry is presented directly while the FIFO holds data.
        axi.o_wvalid = !fifo_empty;
        axi.o_wlast  = !fifo_empty && (beat_q == LAST_BEAT);
        axi.o_wdata  = fifo_empty ? '0 : mem[rd_ptr_q];
        if (!fifo_empty && axi.i_wready && beat_q == LAST_BEAT) begin
          state_d = W_RESP;
        end
      end
      W_RESP: begin
        axi.o_bready = 1'b1;
        if (axi.i_bvalid) begin
          state_d = (b_left_q == 16'd1) ? W_DONE : W_IDLE;
        end
      end
      W_DONE: begin
        o_done  = 1'b1;
        state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_rsp_burst_mover.sv
// tb/tb_rsp_burst_mover.sv - directed self-checking bench for rsp_burst_mover
module tb_rsp_burst_mover;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [31:0]  i_src_base, i_dst_base;
  logic [15:0]  i_num_bursts;
  logic         o_busy, o_done, o_err;
  logic [127:0] o_x;
  logic         o_x_valid, o_x_last;
  logic [127:0] i_y;
  logic         i_y_valid;

  rsp_burst_mover_if #(.DATA_W(128), .ADDR_W(32)) axi ();

  rsp_burst_mover #(.DATA_W(128), .ADDR_W(32), .BURST_LEN(8), .FIFO_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_src_base(i_src_base), .i_dst_base(i_dst_base), .i_num_bursts(i_num_bursts),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .axi(axi),
    .o_x(o_x), .o_x_valid(o_x_valid), .o_x_last(o_x_last),
    .i_y(i_y), .i_y_valid(i_y_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rd_data(input logic [31:0] a, input int b);
    return {a, a + 32'(b) * 32'h10, a ^ 32'hDEADBEEF, 32'(b)};
  endfunction

  // memory-side model state
  logic [31:0]  rq [$];
  logic [31:0]  ar_log [$];
  logic [31:0]  aw_log [$];
  int           rbeat = 0, b_pend = 0, b_idx = 0, err_burst = -1;
  int           wmode = 0, wphase = 0, w_idx = 0;
  int           requested = 0, popped = 0, outstanding = 0, max_occ = 0, max_out = 0;
  int           done_cnt = 0, done_base = 0;
  bit           err_watch = 0, any_valid = 0, seen_busy = 0;
  logic [31:0]  cur_src = '0;
  logic [127:0] y_d [3];
  logic [2:0]   y_v = '0;

  // All model activity happens on the falling edge: DUT outputs are settled
  // and the drives set here are what the DUT samples on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      rbeat = 0; b_pend = 0; wphase = 0; outstanding = 0; err_watch = 0;
      axi.i_arready = 1'b0; axi.i_awready = 1'b0; axi.i_wready = 1'b0;
      axi.i_rvalid = 1'b0; axi.i_rlast = 1'b0; axi.i_rdata = '0; axi.i_rresp = 2'b00;
      axi.i_bvalid = 1'b0; axi.i_bresp = 2'b00;
      y_v = '0; i_y_valid = 1'b0; i_y = '0;
    end else begin
      if (err_watch) begin
        check_eq("err_after_bresp", o_err, 1'b1);
        err_watch = 0;
      end
      if (o_done) done_cnt++;
      if (o_busy) seen_busy = 1;
      if (axi.o_arvalid || axi.o_awvalid || axi.o_wvalid || o_x_valid) any_valid = 1;

      i_y = y_d[2]; i_y_valid = y_v[2];
      y_d[2] = y_d[1]; y_d[1] = y_d[0]; y_d[0] = o_x;
      y_v = {y_v[1:0], o_x_valid};

      if (rq.size() > 0) begin
        axi.i_rvalid = 1'b1;
        axi.i_rdata  = rd_data(rq[0], rbeat);
        axi.i_rlast  = (rbeat == 7);
        axi.i_rresp  = 2'b00;
        if (axi.o_rready) begin
          if (rbeat == 7) begin
            void'(rq.pop_front());
            rbeat = 0;
            outstanding--;
          end else begin
            rbeat++;
          end
        end
      end else begin
        axi.i_rvalid = 1'b0;
        axi.i_rlast  = 1'b0;
      end

      axi.i_arready = 1'b1;
      if (axi.o_arvalid) begin
        rq.push_back(axi.o_araddr);
        ar_log.push_back(axi.o_araddr);
        outstanding++;
        requested += 8;
      end

      axi.i_awready = 1'b1;
      if (axi.o_awvalid) aw_log.push_back(axi.o_awaddr);

      axi.i_bvalid = (b_pend > 0);
      axi.i_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      if (axi.i_bvalid && axi.o_bready) begin
        if (b_idx == err_burst) begin
          check_eq("err_before_bresp", o_err, 1'b0);
          err_watch = 1;
        end
        b_pend--;
        b_idx++;
      end

      axi.i_wready = (wmode != 0) ? (wphase == 0) : 1'b1;
      wphase = (wphase + 1) % 4;
      if (axi.o_wvalid && axi.i_wready) begin
        check_eq("wdata", axi.o_wdata, rd_data(cur_src + 32'(w_idx / 8) * 32'h80, w_idx % 8));
        check_eq("wlast", axi.o_wlast, (w_idx % 8) == 7);
        if (axi.o_wlast) b_pend++;
        w_idx++;
        popped++;
      end

      if (requested - popped > max_occ) max_occ = requested - popped;
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    ar_log.delete(); aw_log.delete();
    w_idx = 0; requested = 0; popped = 0; max_occ = 0; max_out = 0; b_idx = 0;
    any_valid = 0; seen_busy = 0;
    cur_src = s; done_base = done_cnt;
    i_src_base = s; i_dst_base = d; i_num_bursts = n; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == done_base; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("done_pulses", done_cnt - done_base, 1);
    check_eq("busy_after_done", o_busy, 1'b0);
  endtask

  logic [31:0] basic_ar [4] = '{32'h0, 32'h80, 32'h100, 32'h180};
  logic [31:0] basic_aw [4] = '{32'h4000, 32'h4080, 32'h4100, 32'h4180};
  logic [31:0] wrap_ar  [2] = '{32'hFFFFFF80, 32'h00000000};

  initial begin
    rst = 1'b1; i_start = 1'b0; i_src_base = '0; i_dst_base = '0; i_num_bursts = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", o_busy, 1'b0);
    check_eq("rst_err", o_err, 1'b0);
    check_eq("rst_valids", {axi.o_arvalid, axi.o_awvalid, axi.o_wvalid, o_x_valid, o_done}, 5'b0);
    check_eq("rst_readies", {axi.o_rready, axi.o_bready}, 2'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic transfer
    start_xfer(32'h0, 32'h4000, 16'd4);
    check_eq("busy_after_start", o_busy, 1'b1);
    wait_done(2000);
    check_eq("basic_ar_count", ar_log.size(), 4);
    check_eq("basic_aw_count", aw_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check_eq("basic_araddr", ar_log[k], basic_ar[k]);
      check_eq("basic_awaddr", aw_log[k], basic_aw[k]);
    end
    check_eq("basic_wbeats", w_idx, 32);
    check_eq("basic_err", o_err, 1'b0);

    // zero length
    start_xfer(32'h1000, 32'h2000, 16'd0);
    check_eq("zero_done", o_done, 1'b1);
    check_eq("zero_busy", o_busy, 1'b0);
    @(negedge clk);
    check_eq("zero_done_single", o_done, 1'b0);
    repeat (6) @(negedge clk);
    check_eq("zero_no_valid", any_valid, 1'b0);
    check_eq("zero_never_busy", seen_busy, 1'b0);

    // write back-pressure
    wmode = 1;
    start_xfer(32'h1000, 32'h8000, 16'd8);
    wait_done(4000);
    wmode = 0;
    check_eq("bp_wbeats", w_idx, 64);
    check_eq("bp_ar_count", ar_log.size(), 8);
    check_eq("bp_occ_le_32", max_occ <= 32, 1'b1);
    check_eq("bp_out_le_4", max_out <= 4, 1'b1);

    // write response error on the second of three bursts
    err_burst = 1;
    start_xfer(32'h3000, 32'h5000, 16'd3);
    wait_done(2000);
    check_eq("err_bursts", b_idx, 3);
    check_eq("err_wbeats", w_idx, 24);
    check_eq("err_sticky_done", o_err, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("err_persists", o_err, 1'b1);
    err_burst = -1;

    // address wrap; the accepted start also clears the error flag
    start_xfer(32'hFFFFFF80, 32'h0100, 16'd2);
    check_eq("err_cleared_by_start", o_err, 1'b0);
    wait_done(2000);
    check_eq("wrap_ar_count", ar_log.size(), 2);
    for (int k = 0; k < 2; k++) check_eq("wrap_araddr", ar_log[k], wrap_ar[k]);
    check_eq("wrap_wbeats", w_idx, 16);

    // reset in the middle of a transfer
    start_xfer(32'h0, 32'h9000, 16'd8);
    for (int i = 0; i < 2000 && w_idx < 10; i++) @(negedge clk);
    check_eq("mid_wbeats_reached", w_idx >= 10, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_status", {o_busy, o_done, o_err}, 3'b0);
    check_eq("mid_rst_valids", {axi.o_arvalid, axi.o_awvalid, axi.o_wvalid, o_x_valid, o_x_last, axi.o_wlast}, 6'b0);
    check_eq("mid_rst_readies", {axi.o_rready, axi.o_bready}, 2'b0);
    check_eq("mid_rst_addrs", {axi.o_araddr, axi.o_awaddr}, 64'h0);
    check_eq("mid_rst_wdata", axi.o_wdata, 128'h0);
    check_eq("mid_rst_x", o_x, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    start_xfer(32'h2000, 32'h6000, 16'd1);
    wait_done(2000);
    check_eq("post_rst_ar_count", ar_log.size(), 1);
    check_eq("post_rst_araddr", ar_log[0], 32'h2000);
    check_eq("post_rst_aw_count", aw_log.size(), 1);
    check_eq("post_rst_awaddr", aw_log[0], 32'h6000);
    check_eq("post_rst_wbeats", w_idx, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
